// File: rtl/sap_acc_shift.sv
// rtl/sap_acc_shift.sv - SAP accumulator with multi-cycle shift/rotate, inc/dec and flags
// Optional feature macro: ACC_SAT_EN (saturating INC/DEC instead of wrap-around)
module sap_acc_shift #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               nLa,
  input  logic               Ea,
  input  logic [WIDTH-1:0]   Acc_in,
  output logic [WIDTH-1:0]   Acc_W,
  output logic [WIDTH-1:0]   Acc_add_sup,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               zero,
  output logic               neg,
  output logic               cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0]   ONE_D = WIDTH'(1);
  localparam logic [SHAMT_W-1:0] ONE_C = SHAMT_W'(1);

  state_t             state, state_nx;
  logic [WIDTH-1:0]   data, data_nx;
  logic               cout_r, cout_nx;
  logic [2:0]         op_r, op_nx;
  logic [SHAMT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0]   step_data;
  logic               step_cout;
  logic [SHAMT_W-1:0] start_cnt;

  assign Acc_add_sup = data;
  assign Acc_W       = Ea ? data : {WIDTH{1'bz}};
  assign zero        = ~|data;
  assign neg         = data[WIDTH-1];
  assign cout        = cout_r;

  // INC/DEC always take exactly one step regardless of shamt
  assign start_cnt = op[2] & op[1] ? ONE_C : shamt;

  always_comb begin
    step_data = data;
    step_cout = cout_r;
    case (op_r)
      3'b000: ;
      3'b001: begin step_data = {data[WIDTH-2:0], 1'b0};          step_cout = data[WIDTH-1]; end
      3'b010: begin step_data = {1'b0, data[WIDTH-1:1]};          step_cout = data[0];       end
      3'b011: begin step_data = {data[WIDTH-1], data[WIDTH-1:1]}; step_cout = data[0];       end
      3'b100: begin step_data = {data[WIDTH-2:0], data[WIDTH-1]}; step_cout = data[WIDTH-1]; end
      3'b101: begin step_data = {data[0], data[WIDTH-1:1]};       step_cout = data[0];       end
`ifdef ACC_SAT_EN
      3'b110: begin step_data = (&data) ? data : data + ONE_D;    step_cout = &data;         end
      3'b111: begin step_data = (~|data) ? data : data - ONE_D;   step_cout = ~|data;        end
`else
      3'b110: begin step_data = data + ONE_D;                     step_cout = &data;         end
      3'b111: begin step_data = data - ONE_D;                     step_cout = ~|data;        end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    data_nx  = data;
    cout_nx  = cout_r;
    op_nx    = op_r;
    cnt_nx   = cnt;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (!nLa) begin
          data_nx = Acc_in;
          cout_nx = 1'b0;
        end else if (start && op != 3'b000) begin
          op_nx    = op;
          cnt_nx   = start_cnt;
          state_nx = (start_cnt != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (!nLa) begin
          data_nx  = Acc_in;
          cout_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          data_nx = step_data;
          cout_nx = step_cout;
          cnt_nx  = cnt - ONE_C;
          if (cnt == ONE_C) state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (!nLa) begin
          data_nx = Acc_in;
          cout_nx = 1'b0;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      data   <= '0;
      cout_r <= 1'b0;
      op_r   <= 3'b000;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      data   <= data_nx;
      cout_r <= cout_nx;
      op_r   <= op_nx;
      cnt    <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_sap_acc_shift.sv
// tb/tb_sap_acc_shift.sv - self-checking bench for sap_acc_shift against an arithmetic reference model
module tb_sap_acc_shift;

  logic       clk = 1'b0;
  logic       clr, nLa, Ea, start;
  logic [7:0] Acc_in;
  wire  [7:0] Acc_W;
  logic [7:0] Acc_add_sup;
  logic [2:0] op;
  logic [2:0] shamt;
  logic       busy, done, zero, neg, cout;

  int tests = 0;
  int fails = 0;
  int unsigned md;
  int unsigned mc;

  sap_acc_shift #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .clr(clr), .nLa(nLa), .Ea(Ea), .Acc_in(Acc_in), .Acc_W(Acc_W),
    .Acc_add_sup(Acc_add_sup), .op(op), .shamt(shamt), .start(start),
    .busy(busy), .done(done), .zero(zero), .neg(neg), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int eb, input int ed);
    chk({tag, "_data"}, 32'(Acc_add_sup), md);
    chk({tag, "_zero"}, 32'(zero), (md == 0) ? 1 : 0);
    chk({tag, "_neg"},  32'(neg),  (md >= 128) ? 1 : 0);
    chk({tag, "_cout"}, 32'(cout), mc);
    chk({tag, "_busy"}, 32'(busy), eb);
    chk({tag, "_done"}, 32'(done), ed);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference step: plain arithmetic on an unsigned 0..255 value
  task automatic mstep(input int o);
    int unsigned d;
    d = md;
    case (o)
      1: begin md = (d * 2) % 256;                  mc = d / 128; end
      2: begin md = d / 2;                          mc = d % 2;   end
      3: begin md = d / 2 + ((d >= 128) ? 128 : 0); mc = d % 2;   end
      4: begin md = (d * 2) % 256 + d / 128;        mc = d / 128; end
      5: begin md = d / 2 + (d % 2) * 128;          mc = d % 2;   end
`ifdef ACC_SAT_EN
      6: begin md = (d == 255) ? 255 : d + 1;       mc = (d == 255) ? 1 : 0; end
      7: begin md = (d == 0) ? 0 : d - 1;           mc = (d == 0) ? 1 : 0;   end
`else
      6: begin md = (d + 1) % 256;                  mc = (d == 255) ? 1 : 0; end
      7: begin md = (d + 255) % 256;                mc = (d == 0) ? 1 : 0;   end
`endif
      default: ;
    endcase
  endtask

  task automatic load(input int unsigned v);
    nLa = 1'b0;
    Acc_in = 8'(v);
    tick();
    nLa = 1'b1;
    md = v % 256;
    mc = 0;
  endtask

  task automatic do_op(input int o, input int sh, input bit poke);
    int n;
    n = (o >= 6) ? 1 : sh;
    start = 1'b1;
    op = 3'(o);
    shamt = 3'(sh);
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      chk_all("run", 1, 0);
      if (poke && k == 0) begin
        start = 1'b1;
        op = 3'b001;
        shamt = 3'd7;
      end
      tick();
      start = 1'b0;
      mstep(o);
    end
    chk_all("done", 0, 1);
    tick();
    chk_all("idle", 0, 0);
  endtask

  initial begin
    clr = 1'b1; nLa = 1'b1; Ea = 1'b0; start = 1'b0;
    Acc_in = 8'h00; op = 3'b000; shamt = 3'd0;
    md = 0; mc = 0;
    #3;
    chk_all("reset", 0, 0);
    clr = 1'b0;
    tick();

    load(8'h33);
    chk_all("load", 0, 0);
    Ea = 1'b1;
    #1;
    chk("bus_drive", 32'(Acc_W), 32'h33);
    Ea = 1'b0;
    #1;
    // an undriven bus reads as z, or as 0 where the simulator has no z state
    tests++;
    assert (Acc_W === 8'hzz || Acc_W === 8'h00) else begin
      fails++;
      $error("FAIL bus_release observed=%0h expected=zz", Acc_W);
    end
    Acc_in = 8'hCC;
    tick();
    chk_all("hold", 0, 0);

    load(8'h81); do_op(1, 3, 0);
    chk("sll_final", 32'(Acc_add_sup), 32'h08);
    load(8'h80); do_op(3, 2, 0);
    chk("sra_final", 32'(Acc_add_sup), 32'hE0);
    load(8'h01); do_op(5, 1, 0);
    chk("ror_final", 32'(Acc_add_sup), 32'h80);
    load(8'hFF); do_op(6, 5, 0);
`ifdef ACC_SAT_EN
    chk("inc_wrap", 32'(Acc_add_sup), 32'hFF);
`else
    chk("inc_wrap", 32'(Acc_add_sup), 32'h00);
`endif
    load(8'h00); do_op(7, 0, 0);
`ifdef ACC_SAT_EN
    chk("dec_wrap", 32'(Acc_add_sup), 32'h00);
`else
    chk("dec_wrap", 32'(Acc_add_sup), 32'hFF);
`endif

    load(8'h96); do_op(2, 0, 0);
    load(8'hC3); do_op(2, 4, 1);

    start = 1'b1; op = 3'b000; shamt = 3'd5;
    tick();
    start = 1'b0;
    chk_all("nop", 0, 0);

    load(8'h11);
    start = 1'b1; op = 3'b001; shamt = 3'd5;
    tick();
    start = 1'b0;
    tick(); mstep(1);
    tick(); mstep(1);
    chk_all("pre_abort", 1, 0);
    nLa = 1'b0; Acc_in = 8'h5A;
    tick();
    nLa = 1'b1; md = 8'h5A; mc = 0;
    chk_all("abort", 0, 0);
    tick();
    chk_all("abort_idle", 0, 0);

    load(8'h0F);
    start = 1'b1; op = 3'b001; shamt = 3'd7;
    tick();
    start = 1'b0;
    tick(); mstep(1);
    chk_all("pre_clr", 1, 0);
    #2 clr = 1'b1;
    #1;
    md = 0; mc = 0;
    chk_all("clr_async", 0, 0);
    clr = 1'b0;
    tick();
    chk_all("clr_idle", 0, 0);
    tick();
    chk_all("clr_nodone", 0, 0);

    load(8'h42);
    start = 1'b1; op = 3'b100; shamt = 3'd1;
    tick();
    start = 1'b0;
    tick(); mstep(4);
    nLa = 1'b0; Acc_in = 8'hA7;
    chk_all("done_pre_load", 0, 1);
    tick();
    nLa = 1'b1; md = 8'hA7; mc = 0;
    chk_all("done_load", 0, 0);

    for (int i = 0; i < 24; i++) begin
      load($urandom_range(0, 255));
      do_op($urandom_range(1, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
